// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared state type and default sizing for the FIFO write arbiter
package fifo_arb_pkg;

    localparam int DEF_DATASIZE = 8;
    localparam int DEF_NREQ     = 4;
    localparam int DEF_BURST    = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rtl/fifo_wr_arbiter_rr_pick.sv - combinational round-robin pick starting after the last grantee
module rr_pick #(
    parameter  int NREQ = 4,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic            found,
    output logic [IW-1:0]   idx
);

    // Scan from farthest to nearest so the nearest valid candidate after last wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = NREQ; i >= 1; i--) begin
            int c;
            c = (int'(last) + i) % NREQ;
            if (req[c]) begin
                found = 1'b1;
                idx   = IW'(c);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter feeding a single FIFO write port
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int DATASIZE = DEF_DATASIZE,
    parameter  int NREQ     = DEF_NREQ,
    parameter  int BURST    = DEF_BURST,
    localparam int IW       = $clog2(NREQ)
) (
    input  logic                     wclk,
    input  logic                     wrst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DATASIZE-1:0] req_data,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     wfull,
    output logic                     winc,
    output logic [DATASIZE-1:0]      wdata,
    output logic [IW-1:0]            grant_id,
    output logic                     busy
);

    localparam int             CW        = $clog2(BURST) + 1;
    localparam logic [CW-1:0]  LAST_BEAT = CW'(BURST - 1);

    arb_state_t    state;
    logic [IW-1:0] last;
    logic [CW-1:0] count;
    logic          pick_found;
    logic [IW-1:0] pick_idx;
    logic          cur_valid;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req   (req_valid),
        .last  (last),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        cur_valid = 1'b0;
        wdata     = req_data[DATASIZE-1:0];
        for (int k = 0; k < NREQ; k++) begin
            if (grant_id == IW'(k)) begin
                cur_valid = req_valid[k];
                wdata     = req_data[k*DATASIZE +: DATASIZE];
            end
        end
    end

    assign winc = (state == GRANT) && cur_valid && !wfull;
    assign busy = (state == GRANT);

    always_comb begin
        req_ready = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant_id == IW'(k)) begin
                req_ready[k] = winc;
            end
        end
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            state    <= IDLE;
            count    <= '0;
            grant_id <= '0;
            last     <= IW'(NREQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_id <= pick_idx;
                        count    <= '0;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    // A full FIFO only stalls the burst; a dropped valid or the final beat ends it.
                    if (!cur_valid || (winc && count == LAST_BEAT)) begin
                        state <= IDLE;
                        last  <= grant_id;
                        count <= '0;
                    end else if (winc) begin
                        count <= count + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed vectors plus randomized model and scoreboard for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

    localparam int DW = 8;
    localparam int NR = 4;
    localparam int BU = 4;
    localparam int IW = 2;

    logic             wclk = 1'b0;
    logic             wrst = 1'b1;
    logic [NR-1:0]    req_valid = '0;
    logic [NR*DW-1:0] req_data = '0;
    logic [NR-1:0]    req_ready;
    logic             wfull = 1'b0;
    logic             winc;
    logic [DW-1:0]    wdata;
    logic [IW-1:0]    grant_id;
    logic             busy;

    int n_pass  = 0;
    int n_total = 0;

    always #5 wclk = ~wclk;

    fifo_wr_arbiter #(.DATASIZE(DW), .NREQ(NR), .BURST(BU)) dut (
        .wclk      (wclk),
        .wrst      (wrst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wfull     (wfull),
        .winc      (winc),
        .wdata     (wdata),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        else
            n_pass++;
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] rv;
        logic       wf;
        logic       e_winc;
        logic       e_busy;
        logic       chk_gid;
        logic [1:0] e_gid;
        logic [3:0] e_ready;
    } vec_t;

    vec_t vt[$];

    task automatic addv(input logic rst, input logic [3:0] rv, input logic wf, input logic ew,
                        input logic eb, input logic cg, input logic [1:0] eg, input logic [3:0] er);
        vec_t v;
        v = '{rst, rv, wf, ew, eb, cg, eg, er};
        vt.push_back(v);
    endtask

    // Spec-level reference: next grantee is the first valid index after the last one.
    function automatic int rr_next(input logic [NR-1:0] rv, input int last);
        for (int j = 1; j <= NR; j++)
            if (rv[(last + j) % NR]) return (last + j) % NR;
        return -1;
    endfunction

    bit            m_granted;
    int            m_gid, m_last, m_beats;
    logic [5:0]    seq_p[NR];
    logic [5:0]    sb_seq[NR];

    initial begin
        // Single requester streaming 6 words: 1 bubble, 4 beats, 1 bubble, 2 beats.
        addv(1, 4'b0000, 0, 0, 0, 1, 0, 4'b0000);
        addv(0, 4'b0001, 0, 0, 0, 0, 0, 4'b0000);
        repeat (4) addv(0, 4'b0001, 0, 1, 1, 1, 0, 4'b0001);
        addv(0, 4'b0001, 0, 0, 0, 0, 0, 4'b0000);
        repeat (2) addv(0, 4'b0001, 0, 1, 1, 1, 0, 4'b0001);
        addv(0, 4'b0000, 0, 0, 1, 1, 0, 4'b0000);
        addv(0, 4'b0000, 0, 0, 0, 0, 0, 4'b0000);
        // Requester 2 stalled by a full FIFO for 5 cycles mid-burst.
        addv(0, 4'b0100, 0, 0, 0, 0, 0, 4'b0000);
        repeat (2) addv(0, 4'b0100, 0, 1, 1, 1, 2, 4'b0100);
        repeat (5) addv(0, 4'b0100, 1, 0, 1, 1, 2, 4'b0000);
        repeat (2) addv(0, 4'b0100, 0, 1, 1, 1, 2, 4'b0100);
        addv(0, 4'b0000, 0, 0, 0, 0, 0, 4'b0000);
        // Requester 1 drops after 2 words while 3 waits.
        addv(0, 4'b0010, 0, 0, 0, 0, 0, 4'b0000);
        repeat (2) addv(0, 4'b1010, 0, 1, 1, 1, 1, 4'b0010);
        addv(0, 4'b1000, 0, 0, 1, 1, 1, 4'b0000);
        addv(0, 4'b1000, 0, 0, 0, 0, 0, 4'b0000);
        addv(0, 4'b1000, 0, 1, 1, 1, 3, 4'b1000);
        // Reset mid-burst by requester 1; requester 0 wins afterwards.
        addv(0, 4'b0000, 0, 0, 1, 1, 3, 4'b0000);
        addv(0, 4'b0010, 0, 0, 0, 0, 0, 4'b0000);
        addv(0, 4'b0010, 0, 1, 1, 1, 1, 4'b0010);
        addv(1, 4'b0011, 0, 1, 1, 1, 1, 4'b0010);
        addv(0, 4'b0011, 0, 0, 0, 1, 0, 4'b0000);
        addv(0, 4'b0011, 0, 1, 1, 1, 0, 4'b0001);

        req_data = 32'hA3A2A1A0;
        wrst = 1'b1;
        repeat (2) @(posedge wclk);
        #1;

        foreach (vt[i]) begin
            wrst      = vt[i].rst;
            req_valid = vt[i].rv;
            wfull     = vt[i].wf;
            @(negedge wclk);
            check($sformatf("tbl%0d_winc", i), winc, vt[i].e_winc);
            check($sformatf("tbl%0d_busy", i), busy, vt[i].e_busy);
            check($sformatf("tbl%0d_ready", i), req_ready, vt[i].e_ready);
            if (vt[i].chk_gid) begin
                check($sformatf("tbl%0d_gid", i), grant_id, vt[i].e_gid);
                check($sformatf("tbl%0d_wdata", i), wdata, 8'hA0 + vt[i].e_gid);
            end
            @(posedge wclk);
            #1;
        end

        // All four valid: grants 0,1,2,3,0 with 4 beats each and one bubble between.
        wrst = 1'b1; req_valid = '0; wfull = 1'b0;
        @(posedge wclk); #1;
        wrst = 1'b0; req_valid = 4'b1111;
        for (int c = 0; c < 25; c++) begin
            @(negedge wclk);
            check($sformatf("rr%0d_busy", c), busy, (c % 5) != 0);
            check($sformatf("rr%0d_winc", c), winc, (c % 5) != 0);
            if ((c % 5) != 0)
                check($sformatf("rr%0d_gid", c), grant_id, (c / 5) % 4);
            @(posedge wclk); #1;
        end

        // Randomized traffic against the reference model and scoreboard.
        wrst = 1'b1; req_valid = '0; wfull = 1'b0;
        @(posedge wclk); #1;
        m_granted = 0; m_gid = 0; m_last = NR - 1; m_beats = 0;
        for (int k = 0; k < NR; k++) begin
            seq_p[k]  = '0;
            sb_seq[k] = '0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic e_w;
            int   nx;
            wrst  = ($urandom_range(0, 199) == 0);
            wfull = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < NR; k++) begin
                logic [1:0] kk;
                kk = 2'(k);
                req_valid[k] = ($urandom_range(0, 9) < 7);
                req_data[k*DW +: DW] = {kk, seq_p[k]};
            end
            @(negedge wclk);
            e_w = m_granted && req_valid[m_gid] && !wfull;
            check("rnd_winc", winc, e_w);
            check("rnd_busy", busy, m_granted);
            check("rnd_ready", req_ready, e_w ? (32'd1 << m_gid) : 32'd0);
            if (m_granted) check("rnd_gid", grant_id, m_gid);
            if (winc) begin
                logic [1:0] g;
                g = grant_id;
                check("sb_nofull", wfull, 1'b0);
                check("sb_order", wdata, {g, sb_seq[g]});
                sb_seq[g] = sb_seq[g] + 6'd1;
            end
            if (e_w) seq_p[m_gid] = seq_p[m_gid] + 6'd1;
            if (wrst) begin
                m_granted = 0; m_gid = 0; m_last = NR - 1; m_beats = 0;
            end else if (!m_granted) begin
                nx = rr_next(req_valid, m_last);
                if (nx >= 0) begin
                    m_granted = 1; m_gid = nx; m_beats = 0;
                end
            end else if (!req_valid[m_gid]) begin
                m_granted = 0; m_last = m_gid; m_beats = 0;
            end else if (!wfull) begin
                m_beats++;
                if (m_beats == BU) begin
                    m_granted = 0; m_last = m_gid; m_beats = 0;
                end
            end
            @(posedge wclk); #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
